// File: rtl/lsu_dcache_port_pkg.sv
// Shared constants, size encodings and FSM states for the LSU data-cache port.
// Optional misalignment checking is enabled with LSU_MISALIGN_CHECK_EN.
package lsu_dcache_port_pkg;
  localparam int ADDR_W = 10;
  localparam int WIDX_W = 8;
  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Size 2'b11 behaves as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = |off;
    endcase
  endfunction
endpackage

// File: rtl/lsu_lane_merge.sv
// Little-endian lane extract/extend for loads and read-modify-write merge for stores.
// Offset bits below the access size are ignored, so half uses off[1] and word uses none.
module lsu_lane_merge
  import lsu_dcache_port_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merged
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_load   = '0;
    o_merged = i_rd;
    w_byte   = i_rd[{i_off, 3'b000} +: 8];
    w_half   = i_off[1] ? i_rd[31:16] : i_rd[15:0];
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = {{16{i_signed & w_half[15]}}, w_half};
        if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
        else          o_merged[15:0]  = i_wdata[15:0];
      end
      default: begin
        o_load   = i_rd;
        o_merged = i_wdata;
      end
    endcase
  end
endmodule

// File: rtl/lsu_dcache_port.sv
// Load/store port driving the word-addressed data cache: IDLE -> ACCESS -> RESP.
// Define LSU_MISALIGN_CHECK_EN to flag and suppress misaligned half/word accesses.
//
// Handshakes: a request transfers on a rising edge where i_req_valid && o_req_ready;
// a response transfers on a rising edge where o_resp_valid && i_resp_ready. The
// response outputs stay stable while o_resp_valid is high and not yet taken.
module lsu_dcache_port
  import lsu_dcache_port_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic [WIDX_W-1:0] o_dc_a,
  output logic              o_dc_we,
  output logic [DATA_W-1:0] o_dc_wd,
  input  logic [DATA_W-1:0] i_dc_rd,
  output state_t            o_state
);
  state_t              r_state, w_next;
  logic                r_we, r_signed, r_err;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic                w_mis, w_dc_we;
  logic [DATA_W-1:0]   w_load, w_merged;

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_mis = is_misaligned(r_size, r_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  lsu_lane_merge u_lane_merge (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_off    (r_addr[1:0]),
    .i_rd     (i_dc_rd),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    w_dc_we      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_dc_we = r_we & ~w_mis;
        w_next  = ST_RESP;
      end
      ST_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outside a store access the cache sees its own read data written back never.
  assign o_dc_a       = r_addr[ADDR_W-1:2];
  assign o_dc_we      = w_dc_we;
  assign o_dc_wd      = w_dc_we ? w_merged : i_dc_rd;
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;
  assign o_state      = r_state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && i_req_valid) begin
        r_we     <= i_req_we;
        r_size   <= i_req_size;
        r_signed <= i_req_signed;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
      end
      if (r_state == ST_ACCESS) begin
        r_err   <= w_mis;
        r_rdata <= (!r_we && !w_mis) ? w_load : '0;
      end
    end
  end
endmodule

// File: tb/tb_lsu_dcache_port.sv
// Directed bench for lsu_dcache_port with a behavioural 256x32 cache model.
// Define LSU_MISALIGN_CHECK_EN for both bench and RTL to exercise error responses.
module tb_lsu_dcache_port;
  import lsu_dcache_port_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  dc_a;
  logic        dc_we;
  logic [31:0] dc_wd, dc_rd;
  state_t      state;

  logic [31:0] mem [0:255];
  int          n_checks = 0;
  int          n_errors = 0;
  int          we_cnt = 0;

  always #5 clk = ~clk;

  lsu_dcache_port dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_signed(req_signed),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_dc_a(dc_a), .o_dc_we(dc_we), .o_dc_wd(dc_wd), .i_dc_rd(dc_rd),
    .o_state(state)
  );

  assign dc_rd = mem[dc_a];
  always @(posedge clk) if (dc_we) mem[dc_a] <= dc_wd;
  always @(negedge clk) if (dc_we) we_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [9:0] addr, input logic [31:0] wdata);
    int cnt;
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    cnt = 0;
    while (!req_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic get_resp(output logic [31:0] rdata, output logic err, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [9:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    send_req(we, size, sgn, addr, wdata);
    get_resp(rd, er, lat);
    check({tag, "_lat"}, lat, 32'd2);
    check({tag, "_rdata"}, rd, exp_rdata);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, w0;

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_we = 1'b0; req_size = SZ_BYTE; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_dc_we", {31'd0, dc_we}, 32'd0);
    check("rst_state", {30'd0, state}, {30'd0, ST_IDLE});
    reset = 1'b0;

    // Store word: dc_we for exactly one cycle at word index 4, response one cycle later.
    w0 = we_cnt;
    send_req(1'b1, SZ_WORD, 1'b0, 10'h010, 32'hDEADBEEF);
    @(negedge clk);
    check("sw_access_we", {31'd0, dc_we}, 32'd1);
    check("sw_access_a", {24'd0, dc_a}, 32'h04);
    check("sw_access_valid", {31'd0, resp_valid}, 32'd0);
    get_resp(rd, er, lat);
    check("sw_lat", lat, 32'd1);
    check("sw_rdata", rd, 32'd0);
    check("sw_err", {31'd0, er}, 32'd0);
    check("sw_we_cycles", we_cnt - w0, 32'd1);
    xact("lw1", 1'b0, SZ_WORD, 1'b0, 10'h010, 32'd0, 32'hDEADBEEF, 1'b0);

    xact("sb", 1'b1, SZ_BYTE, 1'b0, 10'h012, 32'h0000005A, 32'd0, 1'b0);
    xact("lw2", 1'b0, SZ_WORD, 1'b0, 10'h010, 32'd0, 32'hDE5ABEEF, 1'b0);
    xact("lbs", 1'b0, SZ_BYTE, 1'b1, 10'h013, 32'd0, 32'hFFFFFFDE, 1'b0);
    xact("lbu", 1'b0, SZ_BYTE, 1'b0, 10'h013, 32'd0, 32'h000000DE, 1'b0);
    xact("lbs_pos", 1'b0, SZ_BYTE, 1'b1, 10'h012, 32'd0, 32'h0000005A, 1'b0);
    xact("lhs_neg", 1'b0, SZ_HALF, 1'b1, 10'h010, 32'd0, 32'hFFFFBEEF, 1'b0);

    xact("sw2", 1'b1, SZ_WORD, 1'b0, 10'h020, 32'hAABBCCDD, 32'd0, 1'b0);
    xact("sh", 1'b1, SZ_HALF, 1'b0, 10'h022, 32'h00001234, 32'd0, 1'b0);
    xact("lhs", 1'b0, SZ_HALF, 1'b1, 10'h022, 32'd0, 32'h00001234, 1'b0);
    xact("lw3", 1'b0, SZ_WORD, 1'b0, 10'h020, 32'd0, 32'h1234CCDD, 1'b0);
    xact("lsz3", 1'b0, 2'b11, 1'b1, 10'h020, 32'd0, 32'h1234CCDD, 1'b0);

    w0 = we_cnt;
`ifdef LSU_MISALIGN_CHECK_EN
    xact("lh_mis", 1'b0, SZ_HALF, 1'b0, 10'h021, 32'd0, 32'd0, 1'b1);
    xact("sw_mis", 1'b1, SZ_WORD, 1'b0, 10'h011, 32'h01020304, 32'd0, 1'b1);
    check("mis_no_we", we_cnt - w0, 32'd0);
    xact("lw_after_mis", 1'b0, SZ_WORD, 1'b0, 10'h010, 32'd0, 32'hDE5ABEEF, 1'b0);
`else
    xact("lh_odd", 1'b0, SZ_HALF, 1'b0, 10'h021, 32'd0, 32'h0000CCDD, 1'b0);
    xact("lh_odd_hi", 1'b0, SZ_HALF, 1'b1, 10'h023, 32'd0, 32'h00001234, 1'b0);
    check("odd_no_we", we_cnt - w0, 32'd0);
`endif

    // Back-pressure: response held, second request stalled until the first is taken.
    w0 = we_cnt;
    send_req(1'b0, SZ_WORD, 1'b0, 10'h010, 32'd0);
    repeat (2) @(negedge clk);
    req_we = 1'b0; req_size = SZ_BYTE; req_signed = 1'b0; req_addr = 10'h010;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("hold_rdata", resp_rdata, 32'hDE5ABEEF);
      if (i < 4) @(negedge clk);
    end
    check("hold_no_we", we_cnt - w0, 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("hold_then_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    get_resp(rd, er, lat);
    check("hold_second_lat", lat, 32'd2);
    check("hold_second_rdata", rd, 32'h000000EF);

    // Reset during the ACCESS cycle of a store must abort the write.
    xact("sw_prior", 1'b1, SZ_WORD, 1'b0, 10'h040, 32'h11223344, 32'd0, 1'b0);
    send_req(1'b1, SZ_WORD, 1'b0, 10'h040, 32'hCAFEF00D);
    check("rst_access_we_before", {31'd0, dc_we}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_access_we_after", {31'd0, dc_we}, 32'd0);
    check("rst_access_state", {30'd0, state}, {30'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b0;
    check("rst_access_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_access_ready", {31'd0, req_ready}, 32'd1);
    xact("lw_after_rst", 1'b0, SZ_WORD, 1'b0, 10'h040, 32'd0, 32'h11223344, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
